// File: rtl/alu_rs_if.sv
// Dispatch, result-broadcast and issue signals of the ALU reservation station.
interface alu_rs_if #(
    parameter int unsigned ROB_ID_W = 4
);
    // dispatch request
    logic                dsp_valid;
    logic [6:0]          dsp_opcode;
    logic [2:0]          dsp_func3;
    logic                dsp_func1;
    logic                dsp_is_c_extend;
    logic                dsp_has_q1;
    logic                dsp_has_q2;
    logic [ROB_ID_W-1:0] dsp_q1;
    logic [ROB_ID_W-1:0] dsp_q2;
    logic [31:0]         dsp_v1;
    logic [31:0]         dsp_v2;
    logic [31:0]         dsp_imm;
    logic [31:0]         dsp_off;
    logic [31:0]         dsp_pc;
    logic [ROB_ID_W-1:0] dsp_rob_id;
    logic                full;

    // result broadcast buses
    logic                alu_cdb_valid;
    logic [ROB_ID_W-1:0] alu_cdb_rob;
    logic [31:0]         alu_cdb_data;
    logic                lsb_cdb_valid;
    logic [ROB_ID_W-1:0] lsb_cdb_rob;
    logic [31:0]         lsb_cdb_data;

    // issue to ALU
    logic                iss_valid;
    logic [6:0]          iss_opcode;
    logic [2:0]          iss_func3;
    logic                iss_func1;
    logic                iss_is_c_extend;
    logic [31:0]         iss_data1;
    logic [31:0]         iss_data2;
    logic [31:0]         iss_imm;
    logic [31:0]         iss_off;
    logic [31:0]         iss_pc;
    logic [ROB_ID_W-1:0] iss_rob_target;

    modport master (
        output dsp_valid, dsp_opcode, dsp_func3, dsp_func1, dsp_is_c_extend,
               dsp_has_q1, dsp_has_q2, dsp_q1, dsp_q2, dsp_v1, dsp_v2,
               dsp_imm, dsp_off, dsp_pc, dsp_rob_id,
               alu_cdb_valid, alu_cdb_rob, alu_cdb_data,
               lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_data,
        input  full, iss_valid, iss_opcode, iss_func3, iss_func1, iss_is_c_extend,
               iss_data1, iss_data2, iss_imm, iss_off, iss_pc, iss_rob_target
    );

    modport slave (
        input  dsp_valid, dsp_opcode, dsp_func3, dsp_func1, dsp_is_c_extend,
               dsp_has_q1, dsp_has_q2, dsp_q1, dsp_q2, dsp_v1, dsp_v2,
               dsp_imm, dsp_off, dsp_pc, dsp_rob_id,
               alu_cdb_valid, alu_cdb_rob, alu_cdb_data,
               lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_data,
        output full, iss_valid, iss_opcode, iss_func3, iss_func1, iss_is_c_extend,
               iss_data1, iss_data2, iss_imm, iss_off, iss_pc, iss_rob_target
    );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched instructions until both operands
// are known, snoops the ALU/LSB result buses, issues one ready entry per cycle.
module alu_rs #(
    parameter int unsigned RS_SIZE  = 8,
    parameter int unsigned ROB_ID_W = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    input  logic     rollback,
    alu_rs_if.slave  bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = $clog2(RS_SIZE);
    localparam int unsigned CNT_W  = $clog2(RS_SIZE + 1);

    typedef struct packed {
        logic [6:0]          opcode;
        logic [2:0]          func3;
        logic                func1;
        logic                is_c_extend;
        logic                has_q1;
        logic [ROB_ID_W-1:0] q1;
        logic [DATA_W-1:0]   v1;
        logic                has_q2;
        logic [ROB_ID_W-1:0] q2;
        logic [DATA_W-1:0]   v2;
        logic [DATA_W-1:0]   imm;
        logic [DATA_W-1:0]   off;
        logic [DATA_W-1:0]   pc;
        logic [ROB_ID_W-1:0] rob_id;
    } entry_t;

    logic [RS_SIZE-1:0]  r_busy;
    entry_t              r_ent [RS_SIZE];
    logic [CNT_W-1:0]    r_count;
    logic                r_full;
    logic                r_iss_valid;
    entry_t              r_iss;

    logic                w_alu_valid;
    logic [ROB_ID_W-1:0] w_alu_rob;
    logic [DATA_W-1:0]   w_alu_data;
    logic                w_lsb_valid;
    logic [ROB_ID_W-1:0] w_lsb_rob;
    logic [DATA_W-1:0]   w_lsb_data;
    logic [RS_SIZE-1:0]  w_ready;
    logic                w_iss_hit;
    logic [IDX_W-1:0]    w_iss_idx;
    logic [IDX_W-1:0]    w_free_idx;
    logic                w_accept;
    entry_t              w_dsp_ent;
    entry_t              w_ent_nxt [RS_SIZE];
    logic [RS_SIZE-1:0]  w_busy_nxt;
    logic [CNT_W-1:0]    w_count_nxt;

    assign w_alu_valid = bus.alu_cdb_valid;
    assign w_alu_rob   = bus.alu_cdb_rob;
    assign w_alu_data  = bus.alu_cdb_data;
    assign w_lsb_valid = bus.lsb_cdb_valid;
    assign w_lsb_rob   = bus.lsb_cdb_rob;
    assign w_lsb_data  = bus.lsb_cdb_data;

    // Returns {has_q, value} after snooping both buses; ALU bus wins a double match.
    function automatic logic [DATA_W:0] f_snoop(input logic has_q,
                                                input logic [ROB_ID_W-1:0] q,
                                                input logic [DATA_W-1:0] v);
        logic [DATA_W:0] res;
        res = {has_q, v};
        if (has_q && w_alu_valid && (w_alu_rob == q)) begin
            res = {1'b0, w_alu_data};
        end else if (has_q && w_lsb_valid && (w_lsb_rob == q)) begin
            res = {1'b0, w_lsb_data};
        end
        return res;
    endfunction

    // Lowest-index ready entry (issue) and lowest-index free entry (dispatch).
    always_comb begin
        w_ready    = '0;
        w_iss_hit  = 1'b0;
        w_iss_idx  = '0;
        w_free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            w_ready[i] = r_busy[i] && !r_ent[i].has_q1 && !r_ent[i].has_q2;
            if (w_ready[i]) begin
                w_iss_hit = 1'b1;
                w_iss_idx = IDX_W'(i);
            end
            if (!r_busy[i]) begin
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign w_accept = bus.dsp_valid && !r_full;

    // Incoming entry, with operands captured from a same-cycle broadcast.
    always_comb begin
        logic [DATA_W:0] s1;
        logic [DATA_W:0] s2;
        s1                    = f_snoop(bus.dsp_has_q1, bus.dsp_q1, bus.dsp_v1);
        s2                    = f_snoop(bus.dsp_has_q2, bus.dsp_q2, bus.dsp_v2);
        w_dsp_ent             = '0;
        w_dsp_ent.opcode      = bus.dsp_opcode;
        w_dsp_ent.func3       = bus.dsp_func3;
        w_dsp_ent.func1       = bus.dsp_func1;
        w_dsp_ent.is_c_extend = bus.dsp_is_c_extend;
        w_dsp_ent.has_q1      = s1[DATA_W];
        w_dsp_ent.q1          = bus.dsp_q1;
        w_dsp_ent.v1          = s1[DATA_W-1:0];
        w_dsp_ent.has_q2      = s2[DATA_W];
        w_dsp_ent.q2          = bus.dsp_q2;
        w_dsp_ent.v2          = s2[DATA_W-1:0];
        w_dsp_ent.imm         = bus.dsp_imm;
        w_dsp_ent.off         = bus.dsp_off;
        w_dsp_ent.pc          = bus.dsp_pc;
        w_dsp_ent.rob_id      = bus.dsp_rob_id;
    end

    // Next entry contents: dispatch write into the free slot, wakeup elsewhere.
    always_comb begin
        logic [DATA_W:0] s1;
        logic [DATA_W:0] s2;
        w_busy_nxt = r_busy;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_ent_nxt[i] = r_ent[i];
            s1 = f_snoop(r_ent[i].has_q1, r_ent[i].q1, r_ent[i].v1);
            s2 = f_snoop(r_ent[i].has_q2, r_ent[i].q2, r_ent[i].v2);
            if (w_accept && (w_free_idx == IDX_W'(i))) begin
                w_ent_nxt[i]  = w_dsp_ent;
                w_busy_nxt[i] = 1'b1;
            end else if (r_busy[i]) begin
                w_ent_nxt[i].has_q1 = s1[DATA_W];
                w_ent_nxt[i].v1     = s1[DATA_W-1:0];
                w_ent_nxt[i].has_q2 = s2[DATA_W];
                w_ent_nxt[i].v2     = s2[DATA_W-1:0];
            end
            if (w_iss_hit && (w_iss_idx == IDX_W'(i))) begin
                w_busy_nxt[i] = 1'b0;
            end
        end
        w_count_nxt = r_count + CNT_W'(w_accept) - CNT_W'(w_iss_hit);
    end

    // State and issue registers; rdy freezes everything, rollback flushes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy      <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_iss_valid <= 1'b0;
            r_iss       <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_ent[i] <= '0;
            end
        end else if (rdy) begin
            if (rollback) begin
                r_busy      <= '0;
                r_count     <= '0;
                r_full      <= 1'b0;
                r_iss_valid <= 1'b0;
            end else begin
                r_busy      <= w_busy_nxt;
                r_count     <= w_count_nxt;
                r_full      <= (w_count_nxt == CNT_W'(RS_SIZE));
                r_iss_valid <= w_iss_hit;
                for (int i = 0; i < RS_SIZE; i++) begin
                    r_ent[i] <= w_ent_nxt[i];
                end
                if (w_iss_hit) begin
                    r_iss <= r_ent[w_iss_idx];
                end
            end
        end
    end

    assign bus.full            = r_full;
    assign bus.iss_valid       = r_iss_valid;
    assign bus.iss_opcode      = r_iss.opcode;
    assign bus.iss_func3       = r_iss.func3;
    assign bus.iss_func1       = r_iss.func1;
    assign bus.iss_is_c_extend = r_iss.is_c_extend;
    assign bus.iss_data1       = r_iss.v1;
    assign bus.iss_data2       = r_iss.v2;
    assign bus.iss_imm         = r_iss.imm;
    assign bus.iss_off         = r_iss.off;
    assign bus.iss_pc          = r_iss.pc;
    assign bus.iss_rob_target  = r_iss.rob_id;

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs with an issue-order scoreboard.
module tb_alu_rs;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic rollback;

    always #5 clk = ~clk;

    alu_rs_if #(.ROB_ID_W(4)) bus ();

    alu_rs #(.RS_SIZE(8), .ROB_ID_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .rollback (rollback),
        .bus      (bus)
    );

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] pc;
        logic [31:0] off;
        logic [3:0]  rob;
        logic [6:0]  opc;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    localparam logic [6:0] OP_ALU = 7'b0110011;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] pc,
                        input logic [31:0] off, input logic [3:0] rob, input logic [6:0] opc);
        exp_t e;
        e.d1 = d1; e.d2 = d2; e.pc = pc; e.off = off; e.rob = rob; e.opc = opc;
        sb.push_back(e);
    endtask

    // One clock; sample just after the edge and score any issued instruction.
    task automatic step(input string tag, input logic exp_v);
        exp_t e;
        @(posedge clk);
        #1;
        chk({tag, ".iss_valid"}, 32'(bus.iss_valid), 32'(exp_v));
        if (bus.iss_valid === 1'b1) begin
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL %s.unexpected_issue observed rob=%0d expected none", tag, bus.iss_rob_target);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({tag, ".data1"},  bus.iss_data1, e.d1);
                chk({tag, ".data2"},  bus.iss_data2, e.d2);
                chk({tag, ".pc"},     bus.iss_pc, e.pc);
                chk({tag, ".off"},    bus.iss_off, e.off);
                chk({tag, ".rob"},    32'(bus.iss_rob_target), 32'(e.rob));
                chk({tag, ".opcode"}, 32'(bus.iss_opcode), 32'(e.opc));
            end
        end
    endtask

    task automatic dsp(input logic hq1, input logic [3:0] q1, input logic [31:0] v1,
                       input logic hq2, input logic [3:0] q2, input logic [31:0] v2,
                       input logic [3:0] rob, input logic [31:0] pc, input logic [31:0] off,
                       input logic [6:0] opc);
        bus.dsp_valid  = 1'b1;
        bus.dsp_opcode = opc;
        bus.dsp_has_q1 = hq1; bus.dsp_q1 = q1; bus.dsp_v1 = v1;
        bus.dsp_has_q2 = hq2; bus.dsp_q2 = q2; bus.dsp_v2 = v2;
        bus.dsp_rob_id = rob; bus.dsp_pc = pc; bus.dsp_off = off;
    endtask

    task automatic idle();
        bus.dsp_valid     = 1'b0;
        bus.alu_cdb_valid = 1'b0;
        bus.lsb_cdb_valid = 1'b0;
    endtask

    task automatic alu_bc(input logic [3:0] rob, input logic [31:0] data);
        bus.alu_cdb_valid = 1'b1; bus.alu_cdb_rob = rob; bus.alu_cdb_data = data;
    endtask

    task automatic lsb_bc(input logic [3:0] rob, input logic [31:0] data);
        bus.lsb_cdb_valid = 1'b1; bus.lsb_cdb_rob = rob; bus.lsb_cdb_data = data;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; rollback = 1'b0;
        bus.dsp_valid = 1'b0; bus.dsp_opcode = '0; bus.dsp_func3 = '0; bus.dsp_func1 = 1'b0;
        bus.dsp_is_c_extend = 1'b0; bus.dsp_has_q1 = 1'b0; bus.dsp_has_q2 = 1'b0;
        bus.dsp_q1 = '0; bus.dsp_q2 = '0; bus.dsp_v1 = '0; bus.dsp_v2 = '0;
        bus.dsp_imm = '0; bus.dsp_off = '0; bus.dsp_pc = '0; bus.dsp_rob_id = '0;
        bus.alu_cdb_valid = 1'b0; bus.alu_cdb_rob = '0; bus.alu_cdb_data = '0;
        bus.lsb_cdb_valid = 1'b0; bus.lsb_cdb_rob = '0; bus.lsb_cdb_data = '0;

        // reset values
        #12;
        chk("rst.full",      32'(bus.full), 32'd0);
        chk("rst.iss_valid", 32'(bus.iss_valid), 32'd0);
        chk("rst.data1",     bus.iss_data1, 32'd0);
        chk("rst.pc",        bus.iss_pc, 32'd0);
        chk("rst.rob",       32'(bus.iss_rob_target), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // ready on arrival: issued one edge after dispatch
        dsp(1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 4'd3, 32'h0, 32'h0, OP_ALU);
        push(32'd5, 32'd7, 32'h0, 32'h0, 4'd3, OP_ALU);
        step("add_dsp", 1'b0);
        idle();
        step("add_iss", 1'b1);
        step("add_after", 1'b0);
        chk("add_hold.data1", bus.iss_data1, 32'd5);

        // operand 1 woken by ALU broadcast
        dsp(1'b1, 4'd2, 32'h0, 1'b0, 4'd0, 32'd1, 4'd4, 32'h40, 32'h0, OP_ALU);
        step("sub_dsp", 1'b0);
        idle();
        alu_bc(4'd2, 32'h10);
        push(32'h10, 32'd1, 32'h40, 32'h0, 4'd4, OP_ALU);
        step("sub_wake", 1'b0);
        idle();
        step("sub_iss", 1'b1);
        step("sub_after", 1'b0);

        // operand 2 captured at dispatch from the LSB bus
        dsp(1'b0, 4'd0, 32'h22, 1'b1, 4'd6, 32'h0, 4'd5, 32'h80, 32'h0, OP_ALU);
        lsb_bc(4'd6, 32'hAB);
        push(32'h22, 32'hAB, 32'h80, 32'h0, 4'd5, OP_ALU);
        step("cap_dsp", 1'b0);
        idle();
        step("cap_iss", 1'b1);

        // both operands woken in the same edge from different buses
        dsp(1'b1, 4'd1, 32'h0, 1'b1, 4'd2, 32'h0, 4'd6, 32'hC0, 32'h0, OP_ALU);
        step("dual_dsp", 1'b0);
        idle();
        alu_bc(4'd1, 32'h111);
        lsb_bc(4'd2, 32'h222);
        push(32'h111, 32'h222, 32'hC0, 32'h0, 4'd6, OP_ALU);
        step("dual_wake", 1'b0);
        idle();
        step("dual_iss", 1'b1);

        // fill all entries blocked on tag 9, overflow dispatch ignored
        for (int i = 0; i < 8; i++) begin
            dsp(1'b1, 4'd9, 32'h0, 1'b0, 4'd0, 32'(i), 4'(i), 32'(32'h200 + 4 * i), 32'h0, OP_ALU);
            step("fill_dsp", 1'b0);
            if (i == 6) chk("fill7.full", 32'(bus.full), 32'd0);
        end
        idle();
        chk("fill8.full", 32'(bus.full), 32'd1);
        dsp(1'b0, 4'd0, 32'hDEAD, 1'b0, 4'd0, 32'hBEEF, 4'd15, 32'h999, 32'h0, OP_ALU);
        step("ovf_dsp", 1'b0);
        idle();
        chk("ovf.full", 32'(bus.full), 32'd1);
        alu_bc(4'd9, 32'h55);
        for (int i = 0; i < 8; i++) push(32'h55, 32'(i), 32'(32'h200 + 4 * i), 32'h0, 4'(i), OP_ALU);
        step("fill_wake", 1'b0);
        idle();
        chk("fill_wake.full", 32'(bus.full), 32'd1);
        step("drain0", 1'b1);
        chk("drain0.full", 32'(bus.full), 32'd0);
        for (int i = 1; i < 8; i++) step("drain", 1'b1);
        step("drain_end", 1'b0);

        // rollback with blocked entries and an issue pending
        for (int i = 0; i < 4; i++) begin
            dsp(1'b1, 4'd5, 32'h0, 1'b0, 4'd0, 32'h0, 4'(10 + i), 32'h0, 32'h0, OP_ALU);
            step("rb_fill", 1'b0);
        end
        dsp(1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2, 4'd14, 32'h0, 32'h0, OP_ALU);
        step("rb_ready_dsp", 1'b0);
        rollback = 1'b1;
        dsp(1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 32'd4, 4'd15, 32'h0, 32'h0, OP_ALU);
        step("rb_edge", 1'b0);
        chk("rb.full", 32'(bus.full), 32'd0);
        rollback = 1'b0;
        idle();
        alu_bc(4'd5, 32'h77);
        step("rb_old_tag", 1'b0);
        idle();
        step("rb_quiet1", 1'b0);
        step("rb_quiet2", 1'b0);

        // count restarted at zero: full exactly on the 8th dispatch
        for (int i = 0; i < 8; i++) begin
            dsp(1'b1, 4'd3, 32'h0, 1'b0, 4'd0, 32'h0, 4'(i), 32'h0, 32'h0, OP_ALU);
            step("rb_refill", 1'b0);
            if (i == 6) chk("rb_refill7.full", 32'(bus.full), 32'd0);
        end
        idle();
        chk("rb_refill8.full", 32'(bus.full), 32'd1);
        rollback = 1'b1;
        step("rb2", 1'b0);
        rollback = 1'b0;

        // rdy=0 freezes issue and ignores dispatch
        dsp(1'b0, 4'd0, 32'h31, 1'b0, 4'd0, 32'h32, 4'd2, 32'h300, 32'h4, OP_ALU);
        push(32'h31, 32'h32, 32'h300, 32'h4, 4'd2, OP_ALU);
        step("rdy_dsp", 1'b0);
        rdy = 1'b0;
        dsp(1'b0, 4'd0, 32'h41, 1'b0, 4'd0, 32'h42, 4'd9, 32'h400, 32'h0, OP_ALU);
        step("rdy_low1", 1'b0);
        step("rdy_low2", 1'b0);
        idle();
        rdy = 1'b1;
        step("rdy_iss", 1'b1);
        step("rdy_after", 1'b0);

        // asynchronous reset mid-issue with rdy low
        dsp(1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2, 4'd7, 32'h44, 32'h0, OP_ALU);
        push(32'd1, 32'd2, 32'h44, 32'h0, 4'd7, OP_ALU);
        step("ar_dsp", 1'b0);
        idle();
        step("ar_iss", 1'b1);
        rdy = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("ar.iss_valid", 32'(bus.iss_valid), 32'd0);
        chk("ar.data1",     bus.iss_data1, 32'd0);
        chk("ar.pc",        bus.iss_pc, 32'd0);
        chk("ar.rob",       32'(bus.iss_rob_target), 32'd0);
        chk("ar.full",      32'(bus.full), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        rdy = 1'b1;
        dsp(1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 32'd3, 4'd1, 32'h100, 32'd8, OP_BR);
        push(32'd3, 32'd3, 32'h100, 32'd8, 4'd1, OP_BR);
        step("beq_dsp", 1'b0);
        idle();
        step("beq_iss", 1'b1);
        step("beq_after", 1'b0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station and issue scheduler for the integer ALU. Holds dispatched arithmetic, branch, jump, LUI and AUIPC instructions until both source operands are available. Captures operands from the two result broadcast buses (ALU, LSB). Each cycle it issues at most one ready instruction to the ALU on a registered interface. Sits between the decoder/dispatch stage and the ALU, and is flushed on ROB rollback.

## Interface
- RS_SIZE, 8, number of entries (power of two, ≥2)
- ROB_ID_W, 4, width of ROB tags; DATA_W = ADDR_W = 32 fixed
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- rdy  in  1  global enable; when 0 all state holds
- rollback  in  1  synchronous flush
- dsp_valid  in  1  dispatch request this cycle
- dsp_opcode, dsp_func3, dsp_func1, dsp_is_c_extend  in  7/3/1/1  decoded fields
- dsp_has_q1, dsp_has_q2  in  1  operand 1/2 waits on a ROB tag
- dsp_q1, dsp_q2  in  ROB_ID_W  producer tags
- dsp_v1, dsp_v2  in  32  operand values, used when has_q=0
- dsp_imm, dsp_off, dsp_pc  in  32  immediate, branch/jump offset, pc
- dsp_rob_id  in  ROB_ID_W  destination ROB entry
- full  out  1  no free entry; dispatcher must not assert dsp_valid
- alu_cdb_valid, alu_cdb_rob, alu_cdb_data  in  1/ROB_ID_W/32  ALU result broadcast
- lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_data  in  1/ROB_ID_W/32  load result broadcast
- iss_valid  out  1  ALU inst_valid
- iss_opcode, iss_func3, iss_func1, iss_is_c_extend  out  issued fields
- iss_data1, iss_data2, iss_imm, iss_off, iss_pc  out  32  issued operands
- iss_rob_target  out  ROB_ID_W  issued destination tag

## Operation
- Per entry state: busy, decoded fields, has_q1/q1/v1, has_q2/q2/v2, imm, off, pc, rob_id, is_c_extend.
- Ready: busy && !has_q1 && !has_q2. Readiness is computed from registered state only. A wakeup written at edge E makes the entry eligible in the cycle after E.
- Dispatch is accepted when dsp_valid && !full. The entry written is the lowest-index non-busy entry. dsp_valid while full is ignored with no state change.
- Dispatch capture: if dsp_has_qN and a CDB of that cycle is valid with a tag equal to dsp_qN, store has_qN=0 and vN=that cdb data. The ALU bus takes priority if both match; this is legal only for identical data.
- Wakeup: every busy entry with has_qN and qN equal to a valid CDB tag loads vN and clears has_qN at the edge. Both operands may wake in the same edge, from the same or different buses.
- Select: the lowest-index ready entry. At the edge the issue registers load its fields, iss_data1=v1, iss_data2=v2, iss_valid=1, and its busy bit clears.
- If no entry is ready, iss_valid=0 at the edge; the other iss_* outputs hold their values.
- A dispatched entry that is ready on arrival is not issued in its dispatch cycle.
- count tracks busy entries; count_next = count + accept − issue. full = (count == RS_SIZE).
- A dispatch and an issue in the same cycle are both performed. The dispatch may reuse the slot being freed only on the following cycle.
- Rollback (with rdy=1): clear all busy bits, count=0, iss_valid=0. Dispatch, wakeup and issue of that cycle are discarded.
- Reset (rst=0): same as rollback, and all iss_* outputs are 0. Reset takes effect immediately regardless of clk or rdy.

## Timing
- Reset values: full=0, iss_valid=0, every other iss_* output =0, all entries not busy.
- Dispatch with both operands ready at edge E0: iss_valid=1 after edge E1. The ALU result then appears one edge later, at E2.
- A broadcast at edge E wakes an entry, which can issue at edge E+1.
- Back-to-back dependent instructions: the consumer wakes on the producer's ALU broadcast, then issues one cycle later.
- iss_valid is a single-cycle pulse per instruction with no backpressure. The ALU is fully pipelined and accepts one instruction per cycle.
- full is a registered-state function with no combinational path from dsp_valid.
- rdy=0: no edge effects except asynchronous reset; iss_valid holds its value. The ALU also gates on rdy, so no duplicate issue occurs.

## Test plan
- Reset, then dispatch ADD v1=5, v2=7, rob 3 at E0 -> iss_valid=1 after E1 with iss_data1=5, iss_data2=7, iss_rob_target=3. After E2, iss_valid=0.
- Dispatch SUB with q1=2 pending, then alu_cdb rob=2, data=0x10 at E3 -> no issue before E4. After E4, iss_data1=0x10.
- Dispatch with q2=6 in the same cycle lsb_cdb rob=6, data=0xAB -> the entry is captured ready, and iss_data2=0xAB one edge later.
- Fill 8 blocked entries -> full=1. A 9th dsp_valid is ignored. Broadcast the common tag -> issue in index order 0..7, one per cycle, and full drops after the first issue.
- With 4 busy entries and an issue pending, assert rollback -> iss_valid=0, full=0. A following broadcast of the old tags causes no issue.
- Drop rst asynchronously mid-issue with rdy=0 -> all outputs are 0 immediately. Release, then dispatch BEQ pc=0x100, off=8 -> issued with iss_pc=0x100, iss_off=8.
